// File: rtl/dir_entry_scanner.sv
`default_nettype none
// ============================================================================
// Module      : dir_entry_scanner
// Description : Walks one 512-byte FAT directory sector (16 entries x 32 B)
//               held in the directory BRAM, classifies each entry and hands
//               every playable file entry to the extractor. The title and
//               start cluster returned by the extractor are stored in a small
//               song table that the UI / playback logic reads back.
//               The single BRAM read port is shared: the extractor owns it
//               while the scanner waits for its answer.
// Ports       : clk, rst (sync, active-high)
//               start                      - begin a scan of the loaded sector
//               bram_addr / bram_data      - BRAM read port (2-cycle latency)
//               ext_start_addr/ext_in_valid- launch to extractor
//               ext_dir_bram_addr          - extractor's BRAM address request
//               ext_song_title/ext_cluster/
//               ext_out_valid              - extractor result
//               rd_index/rd_title/rd_cluster - song table read port (1 cycle)
//               song_count, busy, scan_done, table_full, ext_timeout - status
// Revision    : 1.0 - initial release
// ============================================================================
module dir_entry_scanner #(
    parameter int MAX_SONGS   = 8,
    parameter int EXT_TIMEOUT = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    output logic [8:0]                     bram_addr,
    input  logic [7:0]                     bram_data,
    output logic [8:0]                     ext_start_addr,
    output logic                           ext_in_valid,
    input  logic [8:0]                     ext_dir_bram_addr,
    input  logic [79:0]                    ext_song_title,
    input  logic [15:0]                    ext_cluster,
    input  logic                           ext_out_valid,
    input  logic [$clog2(MAX_SONGS)-1:0]   rd_index,
    output logic [79:0]                    rd_title,
    output logic [15:0]                    rd_cluster,
    output logic [$clog2(MAX_SONGS):0]     song_count,
    output logic                           busy,
    output logic                           scan_done,
    output logic                           table_full,
    output logic                           ext_timeout
);

    localparam int c_IDX_W = $clog2(MAX_SONGS);
    localparam int c_CNT_W = c_IDX_W + 1;
    localparam int c_TMR_W = $clog2(EXT_TIMEOUT) + 1;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_RD_NAME  = 4'd1,
        S_WAIT_N   = 4'd2,
        S_RD_ATTR  = 4'd3,
        S_WAIT_A   = 4'd4,
        S_CLASSIFY = 4'd5,
        S_LAUNCH   = 4'd6,
        S_WAIT_EXT = 4'd7,
        S_NEXT     = 4'd8,
        S_DONE     = 4'd9
    } state_t;

    state_t               r_state;
    logic                 r_wait;
    logic [3:0]           r_entry;
    logic [7:0]           r_byte0;
    logic [8:0]           r_bram_addr;
    logic [8:0]           r_ext_start_addr;
    logic                 r_ext_in_valid;
    logic [c_TMR_W-1:0]   r_timer;
    logic [c_CNT_W-1:0]   r_count;
    logic                 r_busy;
    logic                 r_scan_done;
    logic                 r_full;
    logic                 r_timeout;
    logic [79:0]          r_title_mem   [MAX_SONGS];
    logic [15:0]          r_cluster_mem [MAX_SONGS];
    logic [79:0]          r_rd_title;
    logic [15:0]          r_rd_cluster;

    logic [8:0]           w_entry_base;
    logic                 w_end_of_dir;
    logic                 w_skip;
    logic                 w_rd_hit;

    assign w_entry_base = {r_entry, 5'd0};

    // In CLASSIFY the attribute byte is on bram_data (its read was issued
    // in RD_ATTR and the two wait cycles have elapsed).
    assign w_end_of_dir = (r_byte0 == 8'h00);
    assign w_skip       = (r_byte0 == 8'hE5) || (r_byte0 == 8'h2E) ||
                          (bram_data == 8'h0F) || bram_data[3] || bram_data[4];

    // The extractor drives the BRAM directly while we wait on its result.
    assign bram_addr = (r_state == S_WAIT_EXT) ? ext_dir_bram_addr : r_bram_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_wait           <= 1'b0;
            r_entry          <= 4'd0;
            r_byte0          <= 8'd0;
            r_bram_addr      <= 9'd0;
            r_ext_start_addr <= 9'd0;
            r_ext_in_valid   <= 1'b0;
            r_timer          <= '0;
            r_count          <= '0;
            r_busy           <= 1'b0;
            r_scan_done      <= 1'b0;
            r_full           <= 1'b0;
            r_timeout        <= 1'b0;
            for (int i = 0; i < MAX_SONGS; i++) begin
                r_title_mem[i]   <= 80'd0;
                r_cluster_mem[i] <= 16'd0;
            end
        end else begin
            r_scan_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_count   <= '0;
                        r_full    <= 1'b0;
                        r_timeout <= 1'b0;
                        r_entry   <= 4'd0;
                        r_busy    <= 1'b1;
                        r_state   <= S_RD_NAME;
                    end
                end
                S_RD_NAME: begin
                    r_bram_addr <= w_entry_base;
                    r_wait      <= 1'b0;
                    r_state     <= S_WAIT_N;
                end
                S_WAIT_N: begin
                    r_wait <= 1'b1;
                    if (r_wait) begin
                        r_state <= S_RD_ATTR;
                    end
                end
                S_RD_ATTR: begin
                    // Name byte 0 is valid this cycle; issue the attribute read.
                    r_byte0     <= bram_data;
                    r_bram_addr <= w_entry_base + 9'd11;
                    r_wait      <= 1'b0;
                    r_state     <= S_WAIT_A;
                end
                S_WAIT_A: begin
                    r_wait <= 1'b1;
                    if (r_wait) begin
                        r_state <= S_CLASSIFY;
                    end
                end
                S_CLASSIFY: begin
                    if (w_end_of_dir) begin
                        r_state <= S_DONE;
                    end else if (w_skip) begin
                        r_state <= S_NEXT;
                    end else begin
                        r_ext_start_addr <= w_entry_base;
                        r_ext_in_valid   <= 1'b1;
                        r_state          <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    r_ext_in_valid <= 1'b0;
                    r_timer        <= '0;
                    r_state        <= S_WAIT_EXT;
                end
                S_WAIT_EXT: begin
                    if (ext_out_valid) begin
                        r_title_mem[r_count[c_IDX_W-1:0]]   <= ext_song_title;
                        r_cluster_mem[r_count[c_IDX_W-1:0]] <= ext_cluster;
                        r_count <= r_count + c_CNT_W'(1);
                        r_state <= S_NEXT;
                    end else if (r_timer == c_TMR_W'(EXT_TIMEOUT - 1)) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_timer <= r_timer + c_TMR_W'(1);
                    end
                end
                S_NEXT: begin
                    if (r_count == c_CNT_W'(MAX_SONGS)) begin
                        r_full  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (r_entry == 4'd15) begin
                        r_state <= S_DONE;
                    end else begin
                        r_entry <= r_entry + 4'd1;
                        r_state <= S_RD_NAME;
                    end
                end
                S_DONE: begin
                    r_scan_done <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Song table read port; slots beyond the current count read as zero
    // so stale entries from an earlier scan never leak out.
    assign w_rd_hit = ({1'b0, rd_index} < r_count);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_title   <= 80'd0;
            r_rd_cluster <= 16'd0;
        end else if (w_rd_hit) begin
            r_rd_title   <= r_title_mem[rd_index];
            r_rd_cluster <= r_cluster_mem[rd_index];
        end else begin
            r_rd_title   <= 80'd0;
            r_rd_cluster <= 16'd0;
        end
    end

    assign ext_start_addr = r_ext_start_addr;
    assign ext_in_valid   = r_ext_in_valid;
    assign rd_title       = r_rd_title;
    assign rd_cluster     = r_rd_cluster;
    assign song_count     = r_count;
    assign busy           = r_busy;
    assign scan_done      = r_scan_done;
    assign table_full     = r_full;
    assign ext_timeout    = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_dir_entry_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_dir_entry_scanner
// Description : Self-checking bench for dir_entry_scanner. Models the
//               2-cycle directory BRAM and a simple extractor that answers
//               from BRAM contents; expected launches are queued when a
//               directory image is built and popped as launches appear.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dir_entry_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [8:0]  bram_addr;
    logic [7:0]  bram_data = 8'd0;
    logic [8:0]  ext_start_addr;
    logic        ext_in_valid;
    logic [8:0]  ext_dir_bram_addr = 9'd0;
    logic [79:0] ext_song_title = 80'd0;
    logic [15:0] ext_cluster = 16'd0;
    logic        ext_out_valid = 1'b0;
    logic [2:0]  rd_index;
    logic [79:0] rd_title;
    logic [15:0] rd_cluster;
    logic [3:0]  song_count;
    logic        busy;
    logic        scan_done;
    logic        table_full;
    logic        ext_timeout;

    dir_entry_scanner #(.MAX_SONGS(8), .EXT_TIMEOUT(64)) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .bram_addr         (bram_addr),
        .bram_data         (bram_data),
        .ext_start_addr    (ext_start_addr),
        .ext_in_valid      (ext_in_valid),
        .ext_dir_bram_addr (ext_dir_bram_addr),
        .ext_song_title    (ext_song_title),
        .ext_cluster       (ext_cluster),
        .ext_out_valid     (ext_out_valid),
        .rd_index          (rd_index),
        .rd_title          (rd_title),
        .rd_cluster        (rd_cluster),
        .song_count        (song_count),
        .busy              (busy),
        .scan_done         (scan_done),
        .table_full        (table_full),
        .ext_timeout       (ext_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int launch_cyc = 0;
    int done_cyc = 0;
    int done_pulses = 0;

    logic [7:0]  mem [0:511];
    logic [8:0]  exp_launch [$];
    logic [79:0] exp_title [8];
    logic [15:0] exp_clu [8];

    int ext_delay = 3;
    bit ext_silent = 1'b0;

    typedef struct {
        int kind;
        bit silent;
        int exp_count;
        bit exp_full;
        bit exp_to;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- directory BRAM: data 2 cycles after address ----------
    logic [8:0] r_a = 9'd0;
    always @(posedge clk) begin
        r_a       <= bram_addr;
        bram_data <= mem[r_a];
    end

    // ---------------- extractor model --------------------------------------
    bit         m_pend = 1'b0;
    int         m_cnt = 0;
    logic [8:0] m_addr = 9'd0;
    always @(posedge clk) begin
        if (rst) begin
            m_pend        <= 1'b0;
            ext_out_valid <= 1'b0;
        end else begin
            ext_out_valid <= 1'b0;
            if (ext_in_valid) begin
                ext_dir_bram_addr <= ext_start_addr + 9'd1;
                m_addr            <= ext_start_addr;
                m_cnt             <= ext_delay;
                m_pend            <= !ext_silent;
            end else if (m_pend) begin
                if (m_cnt == 0) begin
                    logic [79:0] t;
                    for (int k = 0; k < 10; k++)
                        t[79-8*k -: 8] = mem[int'(m_addr) + k];
                    ext_song_title <= t;
                    ext_cluster    <= {mem[int'(m_addr) + 27], mem[int'(m_addr) + 26]};
                    ext_out_valid  <= 1'b1;
                    m_pend         <= 1'b0;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    // ---------------- monitors / scoreboard --------------------------------
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && ext_in_valid) begin
            launch_cyc = cyc;
            checks++;
            if (exp_launch.size() == 0) begin
                errors++;
                $display("FAIL launch_unexpected: got addr %0d expected no launch", ext_start_addr);
            end else begin
                logic [8:0] e;
                e = exp_launch.pop_front();
                if (ext_start_addr !== e) begin
                    errors++;
                    $display("FAIL launch_addr: got %0d expected %0d", ext_start_addr, e);
                end
            end
        end
        if (!rst && scan_done) begin
            done_pulses++;
            done_cyc = cyc;
        end
    end

    // ---------------- directory image builders -----------------------------
    function automatic logic [79:0] title_of(input int idx, input logic [7:0] b0);
        logic [79:0] t;
        t[79:72] = b0;
        for (int k = 1; k < 10; k++)
            t[79-8*k -: 8] = 8'(8'h40 + idx + k);
        return t;
    endfunction

    task automatic set_entry(input int idx, input logic [7:0] b0, input logic [7:0] attr,
                             input logic [15:0] clu);
        int base;
        base = idx * 32;
        mem[base] = b0;
        for (int k = 1; k < 11; k++)
            mem[base + k] = 8'(8'h40 + idx + k);
        mem[base + 11] = attr;
        mem[base + 26] = clu[7:0];
        mem[base + 27] = clu[15:8];
    endtask

    task automatic build(input int kind);
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        exp_launch.delete();
        for (int i = 0; i < 8; i++) begin
            exp_title[i] = 80'd0;
            exp_clu[i]   = 16'd0;
        end
        case (kind)
            1, 4: begin
                set_entry(0, 8'h53, 8'h20, 16'h0003);
                exp_launch.push_back(9'd0);
                if (kind == 1) begin
                    exp_title[0] = title_of(0, 8'h53);
                    exp_clu[0]   = 16'h0003;
                end
            end
            2: begin
                set_entry(0, 8'hE5, 8'h20, 16'h0011);
                set_entry(1, 8'h41, 8'h0F, 16'h0022);
                set_entry(2, 8'h42, 8'h10, 16'h0033);
                set_entry(3, 8'h43, 8'h20, 16'h0123);
                exp_launch.push_back(9'd96);
                exp_title[0] = title_of(3, 8'h43);
                exp_clu[0]   = 16'h0123;
            end
            default: begin
                for (int i = 0; i < 16; i++)
                    set_entry(i, 8'(8'h50 + i), 8'h20, 16'(16'h0100 + i));
                for (int i = 0; i < 8; i++) begin
                    exp_launch.push_back(9'(i * 32));
                    exp_title[i] = title_of(i, 8'(8'h50 + i));
                    exp_clu[i]   = 16'(16'h0100 + i);
                end
            end
        endcase
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 3000) begin
            @(negedge clk);
            n++;
            if (scan_done) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_done_timeout: got no scan_done expected pulse within 3000 cycles", name);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_table(input string name, input int cnt);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk) rd_index = 3'(i);
            @(negedge clk);
            check($sformatf("%s_rd%0d", name, i), {rd_title, rd_cluster},
                  (i < cnt) ? {exp_title[i], exp_clu[i]} : 96'd0);
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int dp0;
        ext_silent = v.silent;
        build(v.kind);
        dp0 = done_pulses;
        pulse_start();
        wait_done(name);
        check({name, "_count"}, 96'(song_count), 96'(v.exp_count));
        check({name, "_full"}, 96'(table_full), 96'(v.exp_full));
        check({name, "_timeout"}, 96'(ext_timeout), 96'(v.exp_to));
        check({name, "_busy"}, 96'(busy), 96'd0);
        check({name, "_done_pulses"}, 96'(done_pulses - dp0), 96'd1);
        check({name, "_launch_left"}, 96'(exp_launch.size()), 96'd0);
        if (v.silent)
            check({name, "_timeout_latency"}, 96'(done_cyc - launch_cyc), 96'd66);
        check_table(name, v.exp_count);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1;
        start = 1'b0;
        rd_index = 3'd0;
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_outputs",
              96'({bram_addr, ext_start_addr, ext_in_valid, song_count, busy, scan_done,
                   table_full, ext_timeout}), 96'd0);
        check("reset_rd", {rd_title, rd_cluster}, 96'd0);

        vecs[0] = '{kind: 1, silent: 1'b0, exp_count: 1, exp_full: 1'b0, exp_to: 1'b0};
        vecs[1] = '{kind: 2, silent: 1'b0, exp_count: 1, exp_full: 1'b0, exp_to: 1'b0};
        vecs[2] = '{kind: 3, silent: 1'b0, exp_count: 8, exp_full: 1'b1, exp_to: 1'b0};
        vecs[3] = '{kind: 4, silent: 1'b1, exp_count: 0, exp_full: 1'b0, exp_to: 1'b1};
        for (int i = 0; i < 4; i++)
            run_vec(vecs[i], $sformatf("T%0d", i + 1));

        // T5: reset while the extractor owns the BRAM port.
        ext_silent = 1'b0;
        ext_delay  = 30;
        build(1);
        pulse_start();
        n = 0;
        while (!ext_in_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("T5_launch_seen", 96'(ext_in_valid), 96'd1);
        repeat (3) @(negedge clk);
        check("T5_bram_passthru", 96'(bram_addr), 96'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("T5_reset_outputs",
              96'({bram_addr, ext_start_addr, ext_in_valid, song_count, busy, scan_done,
                   table_full, ext_timeout}), 96'd0);
        check("T5_reset_rd", {rd_title, rd_cluster}, 96'd0);
        @(negedge clk) rst = 1'b0;
        ext_delay = 3;
        run_vec(vecs[0], "T5_rerun");

        // T6b: reading beyond the table returns zeros.
        @(negedge clk) rd_index = 3'd5;
        @(negedge clk);
        check("T6_rd_beyond", {rd_title, rd_cluster}, 96'd0);

        // T6: start while busy is ignored and does not clear the count.
        build(3);
        pulse_start();
        n = 0;
        while (song_count != 4'd2 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("T6_reach_two", 96'(song_count), 96'd2);
        pulse_start();
        check("T6_count_kept", 96'(song_count), 96'd2);
        check("T6_busy", 96'(busy), 96'd1);
        wait_done("T6");
        check("T6_count", 96'(song_count), 96'd8);
        check("T6_full", 96'(table_full), 96'd1);
        check("T6_launch_left", 96'(exp_launch.size()), 96'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
